// File: rtl/watch_mode_ctrl.sv
// -----------------------------------------------------------------------------
// watch_mode_ctrl
//
// Button/mode sequencer for the watch/stopwatch pair. Sits between the button
// debouncers and the two counter datapaths: turns debounced button levels into
// single-cycle control pulses, runs the stopwatch run/stop state, and runs the
// watch time-set mode (field select, increment with auto-repeat, idle timeout,
// blink of the selected field).
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-low reset
//   tick_100hz  one-clk pulse at 100 Hz from the watch timebase
//   sw_mode     mode switches; [1]=1 watch, [1]=0 stopwatch; [0] unused
//   btn_L       debounced level: stopwatch run/stop, watch field select
//   btn_R       debounced level: stopwatch clear, watch set enter/exit
//   btn_U       debounced level: watch increment of the selected field
//   sw_run      stopwatch run level
//   sw_clear    one-clk stopwatch clear pulse
//   inc_h       one-clk hour increment pulse
//   inc_m       one-clk minute increment pulse
//   inc_s       one-clk second increment pulse
//   set_active  high while the watch is in set mode
//   sel_field   selected field: 0 hour, 1 minute, 2 second
//   blink       display blink enable for the selected field
//
// All outputs are registered; a button rise shows up on the outputs in the
// cycle after the rise is sampled and pulses last exactly one cycle.
// -----------------------------------------------------------------------------
module watch_mode_ctrl #(
    parameter int REPEAT_DLY  = 50,
    parameter int REPEAT_PER  = 10,
    parameter int SET_TIMEOUT = 1000,
    parameter int BLINK_HALF  = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_100hz,
    input  logic [1:0] sw_mode,
    input  logic       btn_L,
    input  logic       btn_R,
    input  logic       btn_U,
    output logic       sw_run,
    output logic       sw_clear,
    output logic       inc_h,
    output logic       inc_m,
    output logic       inc_s,
    output logic       set_active,
    output logic [1:0] sel_field,
    output logic       blink
);

    localparam int HOLD_W = $clog2(REPEAT_DLY) + 1;
    localparam int REP_W  = $clog2(REPEAT_PER) + 1;
    localparam int TO_W   = $clog2(SET_TIMEOUT) + 1;
    localparam int BL_W   = $clog2(BLINK_HALF) + 1;

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(REPEAT_DLY);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REPEAT_PER);
    localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_PER - 1);
    localparam logic [REP_W-1:0]  REP_ONE  = REP_W'(1);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(SET_TIMEOUT);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(SET_TIMEOUT - 1);
    localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
    localparam logic [BL_W-1:0]   BL_MAX   = BL_W'(BLINK_HALF);
    localparam logic [BL_W-1:0]   BL_LAST  = BL_W'(BLINK_HALF - 1);
    localparam logic [BL_W-1:0]   BL_ONE   = BL_W'(1);

    typedef enum logic {
        SW_STOP = 1'b0,
        SW_RUN  = 1'b1
    } sw_state_e;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_SET  = 1'b1
    } w_state_e;

    // Saturating increments: every counter stops at its parameter value
    // instead of wrapping, even if the reload logic were ever bypassed.
    function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
        return (v == HOLD_MAX) ? v : v + HOLD_ONE;
    endfunction

    function automatic logic [REP_W-1:0] rep_sat_inc(input logic [REP_W-1:0] v);
        return (v == REP_MAX) ? v : v + REP_ONE;
    endfunction

    function automatic logic [TO_W-1:0] to_sat_inc(input logic [TO_W-1:0] v);
        return (v == TO_MAX) ? v : v + TO_ONE;
    endfunction

    function automatic logic [BL_W-1:0] bl_sat_inc(input logic [BL_W-1:0] v);
        return (v == BL_MAX) ? v : v + BL_ONE;
    endfunction

    // State and registered outputs
    sw_state_e         sw_st_q, sw_st_d;
    w_state_e          w_st_q, w_st_d;
    logic              btn_l_q, btn_r_q, btn_u_q;
    logic [1:0]        sel_q, sel_d;
    logic              blink_q, blink_d;
    logic              sw_clear_q, sw_clear_d;
    logic              inc_h_q, inc_h_d;
    logic              inc_m_q, inc_m_d;
    logic              inc_s_q, inc_s_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [BL_W-1:0]   bcnt_q, bcnt_d;

    // Combinational helpers
    logic watch_mode;
    logic rise_l, rise_r, rise_u;
    logic acc_l, acc_r, acc_u;
    logic inc_fire;

    // sw_mode[0] belongs to other blocks on the board.
    logic unused_mode0;
    assign unused_mode0 = sw_mode[0];

    assign watch_mode = sw_mode[1];

    always_comb begin
        // Edge detect. The edge registers track the levels in both modes, so
        // a button held across a mode change never appears as a fresh rise.
        rise_l = btn_L & ~btn_l_q;
        rise_r = btn_R & ~btn_r_q;
        rise_u = btn_U & ~btn_u_q;

        // Simultaneous rises: R beats L beats U; losers are dropped.
        acc_r = rise_r;
        acc_l = rise_l & ~rise_r;
        acc_u = rise_u & ~rise_r & ~rise_l;

        sw_st_d    = sw_st_q;
        sw_clear_d = 1'b0;
        w_st_d     = w_st_q;
        sel_d      = sel_q;
        blink_d    = blink_q;
        hold_d     = hold_q;
        rep_d      = rep_q;
        to_d       = to_q;
        bcnt_d     = bcnt_q;
        inc_fire   = 1'b0;

        // Stopwatch control only reacts in stopwatch mode; its state is kept
        // otherwise so the stopwatch keeps running in the background.
        if (!watch_mode) begin
            if (acc_l) begin
                sw_st_d = (sw_st_q == SW_STOP) ? SW_RUN : SW_STOP;
            end else if (acc_r && (sw_st_q == SW_STOP)) begin
                sw_clear_d = 1'b1;
            end
        end

        if (w_st_q == W_IDLE) begin
            if (watch_mode && acc_r) begin
                w_st_d  = W_SET;
                sel_d   = 2'd0;
                blink_d = 1'b1;
                to_d    = '0;
                bcnt_d  = '0;
                hold_d  = '0;
                rep_d   = '0;
            end
        end else begin
            // Leaving watch mode drops out of set mode without an increment.
            if (!watch_mode || acc_r) begin
                w_st_d = W_IDLE;
            end else begin
                if (acc_l) begin
                    sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
                end

                if (acc_u) begin
                    inc_fire = 1'b1;
                end

                // Auto-repeat: the hold counter runs up to REPEAT_DLY and
                // stays there; from then on the period counter reloads every
                // REPEAT_PER ticks. A field change does not touch either, so
                // pulses simply follow the new selection.
                if (btn_U) begin
                    if (tick_100hz) begin
                        if (hold_q != HOLD_MAX) begin
                            hold_d = hold_sat_inc(hold_q);
                            if (hold_d == HOLD_MAX) begin
                                inc_fire = 1'b1;
                            end
                        end else if (rep_q == REP_LAST) begin
                            rep_d    = '0;
                            inc_fire = 1'b1;
                        end else begin
                            rep_d = rep_sat_inc(rep_q);
                        end
                    end
                end else begin
                    hold_d = '0;
                    rep_d  = '0;
                end

                // Idle timeout: any accepted edge or a held U counts as
                // activity.
                if (acc_l || acc_u || btn_U) begin
                    to_d = '0;
                end else if (tick_100hz) begin
                    if (to_q == TO_LAST) begin
                        w_st_d = W_IDLE;
                    end else begin
                        to_d = to_sat_inc(to_q);
                    end
                end

                if (tick_100hz) begin
                    if (bcnt_q == BL_LAST) begin
                        bcnt_d  = '0;
                        blink_d = ~blink_q;
                    end else begin
                        bcnt_d = bl_sat_inc(bcnt_q);
                    end
                end
            end
        end

        // Whatever path leads to idle, blink is off and the set-mode counters
        // start from zero next time; sel_field is deliberately kept.
        if (w_st_d == W_IDLE) begin
            blink_d  = 1'b0;
            hold_d   = '0;
            rep_d    = '0;
            to_d     = '0;
            bcnt_d   = '0;
            inc_fire = 1'b0;
        end

        // Increments are steered by the selection in force this cycle.
        inc_h_d = inc_fire & (sel_q == 2'd0);
        inc_m_d = inc_fire & (sel_q == 2'd1);
        inc_s_d = inc_fire & (sel_q == 2'd2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_st_q    <= SW_STOP;
            w_st_q     <= W_IDLE;
            btn_l_q    <= 1'b0;
            btn_r_q    <= 1'b0;
            btn_u_q    <= 1'b0;
            sel_q      <= 2'd0;
            blink_q    <= 1'b0;
            sw_clear_q <= 1'b0;
            inc_h_q    <= 1'b0;
            inc_m_q    <= 1'b0;
            inc_s_q    <= 1'b0;
            hold_q     <= '0;
            rep_q      <= '0;
            to_q       <= '0;
            bcnt_q     <= '0;
        end else begin
            sw_st_q    <= sw_st_d;
            w_st_q     <= w_st_d;
            btn_l_q    <= btn_L;
            btn_r_q    <= btn_R;
            btn_u_q    <= btn_U;
            sel_q      <= sel_d;
            blink_q    <= blink_d;
            sw_clear_q <= sw_clear_d;
            inc_h_q    <= inc_h_d;
            inc_m_q    <= inc_m_d;
            inc_s_q    <= inc_s_d;
            hold_q     <= hold_d;
            rep_q      <= rep_d;
            to_q       <= to_d;
            bcnt_q     <= bcnt_d;
        end
    end

    assign sw_run     = (sw_st_q == SW_RUN);
    assign set_active = (w_st_q == W_SET);
    assign sel_field  = sel_q;
    assign blink      = blink_q;
    assign sw_clear   = sw_clear_q;
    assign inc_h      = inc_h_q;
    assign inc_m      = inc_m_q;
    assign inc_s      = inc_s_q;

endmodule
